// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control encodings for the 5-stage core.
package pipe_ctrl_pkg;
  localparam logic [1:0] PCTRL_RUN       = 2'd0;
  localparam logic [1:0] PCTRL_MC_WAIT   = 2'd1;
  localparam logic [1:0] PCTRL_JUMP_PEND = 2'd2;
  localparam logic [31:0] INST_NOP       = 32'h0000_0013;
endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// pipe_hazard_det: combinational load-use hazard compare between EX and ID.
module pipe_hazard_det (
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wen_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);
  assign load_use_o = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != 5'd0) &
                      ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for stalls, flushes and redirects.
// Optional PIPE_CTRL_PERF_EN adds stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MC_TIMEOUT = 64,
  parameter logic [31:0] RST_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  input  logic        ex_is_load_i,
  input  logic        mc_start_i,
  input  logic        mc_done_i,
  input  logic        bus_stall_i,
  output logic        hold_pc_o,
  output logic        keep_if_id_o,
  output logic        keep_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        timeout_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [1:0]  state_o
);
  localparam int CW = $clog2(MC_TIMEOUT + 1);
  logic [1:0]    state, state_nx;
  logic [CW-1:0] mc_cnt;
  logic [31:0]   pend_addr, jaddr;
  logic          load_use, hold, keep_ii, keep_ie, fl_ii, fl_ie, jmp, tmo;
  pipe_hazard_det u_haz (
    .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i),
    .ex_rd_addr_i (ex_rd_addr_i),
    .ex_reg_wen_i (ex_reg_wen_i),
    .ex_is_load_i (ex_is_load_i),
    .load_use_o   (load_use)
  );
  always_comb begin
    hold = 1'b0;
    keep_ii = 1'b0;
    keep_ie = 1'b0;
    fl_ii = 1'b0;
    fl_ie = 1'b0;
    jmp = 1'b0;
    tmo = 1'b0;
    jaddr = RST_PC;
    state_nx = state;
    if (state == PCTRL_RUN) begin
      if (bus_stall_i) begin
        {hold, keep_ii, keep_ie} = 3'b111;
        state_nx = jump_en_i ? PCTRL_JUMP_PEND : PCTRL_RUN;
      end else if (jump_en_i) begin
        {jmp, fl_ii, fl_ie} = 3'b111;
        jaddr = jump_addr_i;
      end else if (mc_start_i) begin
        state_nx = mc_done_i ? PCTRL_RUN : PCTRL_MC_WAIT;
      end else if (load_use) begin
        {hold, keep_ii, fl_ie} = 3'b111;
      end
    end else if (state == PCTRL_MC_WAIT) begin
      if (mc_done_i) begin
        state_nx = PCTRL_RUN;
      end else if (mc_cnt == CW'(MC_TIMEOUT - 1)) begin
        // ID/EX is flushed instead of kept so the stuck op drains as a NOP
        {tmo, hold, keep_ii, fl_ie} = 4'b1111;
        state_nx = PCTRL_RUN;
      end else begin
        {hold, keep_ii, keep_ie} = 3'b111;
      end
    end else if (state == PCTRL_JUMP_PEND) begin
      jaddr = pend_addr;
      if (bus_stall_i) begin
        {hold, keep_ii, keep_ie} = 3'b111;
      end else begin
        {jmp, fl_ii, fl_ie} = 3'b111;
        state_nx = PCTRL_RUN;
      end
    end else begin
      state_nx = PCTRL_RUN;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= PCTRL_RUN;
      mc_cnt <= '0;
      pend_addr <= RST_PC;
    end else begin
      state <= state_nx;
      mc_cnt <= (state == PCTRL_MC_WAIT) ? mc_cnt + 1'b1 : '0;
      if (state == PCTRL_RUN && bus_stall_i && jump_en_i) pend_addr <= jump_addr_i;
    end
  end
  assign hold_pc_o     = rst & hold;
  assign keep_if_id_o  = rst & keep_ii;
  assign keep_id_ex_o  = rst & keep_ie;
  assign flush_if_id_o = rst & fl_ii;
  assign flush_id_ex_o = rst & fl_ie;
  assign jump_en_o     = rst & jmp;
  assign timeout_o     = rst & tmo;
  assign jump_addr_o   = rst ? jaddr : RST_PC;
  assign state_o       = state;
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      stall_cnt_o <= stall_cnt_o + 32'(hold_pc_o);
      flush_cnt_o <= flush_cnt_o + 32'(flush_id_ex_o);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b0;
  logic jump_en_i, ex_reg_wen_i, ex_is_load_i, mc_start_i, mc_done_i, bus_stall_i;
  logic [31:0] jump_addr_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic hold_pc_o, keep_if_id_o, keep_id_ex_o, flush_if_id_o, flush_id_ex_o, jump_en_o, timeout_o;
  logic [31:0] jump_addr_o;
  logic [1:0] state_o;
  int n_cmp = 0, n_err = 0;
  int m_mode = 0, m_wait = 0;
  logic [31:0] m_pend = 32'h0;
  always #5 clk = ~clk;
  pipe_ctrl #(.MC_TIMEOUT(TO), .RST_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_reg_wen_i(ex_reg_wen_i), .ex_is_load_i(ex_is_load_i), .mc_start_i(mc_start_i),
    .mc_done_i(mc_done_i), .bus_stall_i(bus_stall_i), .hold_pc_o(hold_pc_o),
    .keep_if_id_o(keep_if_id_o), .keep_id_ex_o(keep_id_ex_o), .flush_if_id_o(flush_if_id_o),
    .flush_id_ex_o(flush_id_ex_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .timeout_o(timeout_o), .state_o(state_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    {jump_en_i, ex_reg_wen_i, ex_is_load_i, mc_start_i, mc_done_i, bus_stall_i} = '0;
    jump_addr_i = 32'h0;
    {id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i} = '0;
  endtask
  task automatic tick();
    logic hz, e_hold, e_kii, e_kie, e_fii, e_fie, e_j, e_to;
    logic [31:0] e_addr;
    #1;
    hz = ex_is_load_i && ex_reg_wen_i && ex_rd_addr_i != 0 &&
         (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);
    {e_hold, e_kii, e_kie, e_fii, e_fie, e_j, e_to} = '0;
    e_addr = 32'h0;
    chk("state", 32'(state_o), 32'(m_mode));
    if (m_mode == 0) begin
      if (bus_stall_i) begin
        {e_hold, e_kii, e_kie} = 3'b111;
        if (jump_en_i) begin m_mode = 2; m_pend = jump_addr_i; end
      end else if (jump_en_i) begin
        {e_j, e_fii, e_fie} = 3'b111;
        e_addr = jump_addr_i;
      end else if (mc_start_i) begin
        if (!mc_done_i) begin m_mode = 1; m_wait = 0; end
      end else if (hz) {e_hold, e_kii, e_fie} = 3'b111;
    end else if (m_mode == 1) begin
      m_wait++;
      if (mc_done_i) m_mode = 0;
      else if (m_wait == TO) begin {e_to, e_hold, e_kii, e_fie} = 4'b1111; m_mode = 0; end
      else {e_hold, e_kii, e_kie} = 3'b111;
    end else begin
      e_addr = m_pend;
      if (bus_stall_i) {e_hold, e_kii, e_kie} = 3'b111;
      else begin {e_j, e_fii, e_fie} = 3'b111; m_mode = 0; end
    end
    chk("hold_pc", 32'(hold_pc_o), 32'(e_hold));
    chk("keep_if_id", 32'(keep_if_id_o), 32'(e_kii));
    chk("keep_id_ex", 32'(keep_id_ex_o), 32'(e_kie));
    chk("flush_if_id", 32'(flush_if_id_o), 32'(e_fii));
    chk("flush_id_ex", 32'(flush_id_ex_o), 32'(e_fie));
    chk("jump_en", 32'(jump_en_o), 32'(e_j));
    chk("jump_addr", jump_addr_o, e_addr);
    chk("timeout", 32'(timeout_o), 32'(e_to));
    @(negedge clk);
  endtask
  initial begin
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // taken jump in RUN
    jump_en_i = 1; jump_addr_i = 32'h100; tick(); idle();
    // load-use on rs2, then rd=0 gives no bubble
    ex_is_load_i = 1; ex_reg_wen_i = 1; ex_rd_addr_i = 5; id_rs2_addr_i = 5; tick();
    ex_rd_addr_i = 0; id_rs2_addr_i = 0; tick(); idle();
    // multi-cycle op completing after 7 held cycles
    mc_start_i = 1; tick(); idle();
    repeat (7) tick();
    mc_done_i = 1; tick(); idle(); tick();
    // start and done together stays in RUN
    mc_start_i = 1; mc_done_i = 1; tick(); idle(); tick();
    // async reset in the middle of MC_WAIT with 10 cycles elapsed
    mc_start_i = 1; tick(); idle();
    repeat (10) tick();
    jump_en_i = 1; jump_addr_i = 32'h55; bus_stall_i = 1;
    #2 rst = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outs", 32'({hold_pc_o, keep_if_id_o, keep_id_ex_o, flush_if_id_o, flush_id_ex_o, jump_en_o, timeout_o}), 32'd0);
    chk("rst_addr", jump_addr_o, 32'h0);
    m_mode = 0; m_wait = 0; m_pend = 32'h0;
    @(negedge clk); idle(); @(negedge clk);
    rst = 1'b1;
    // timeout with no done
    mc_start_i = 1; tick(); idle();
    repeat (TO) tick();
    tick();
    // jump deferred by a 3-cycle bus stall; second jump ignored
    bus_stall_i = 1; jump_en_i = 1; jump_addr_i = 32'h200; tick();
    jump_addr_i = 32'h300; tick();
    jump_en_i = 0; tick();
    idle(); tick(); tick();
    for (int i = 0; i < 3000; i++) begin
      jump_en_i = ($urandom_range(0, 4) == 0);
      jump_addr_i = $urandom;
      bus_stall_i = ($urandom_range(0, 4) == 0);
      mc_start_i = ($urandom_range(0, 7) == 0);
      mc_done_i = ($urandom_range(0, 5) == 0);
      ex_is_load_i = $urandom_range(0, 1);
      ex_reg_wen_i = $urandom_range(0, 1);
      ex_rd_addr_i = 5'($urandom_range(0, 7));
      id_rs1_addr_i = 5'($urandom_range(0, 7));
      id_rs2_addr_i = 5'($urandom_range(0, 7));
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates the PC hold, the IF/ID and ID/EX keep (stall) controls and the flush controls. Flushes drive the existing pipeline-register hold_flag_i inputs, which load the NOP/zero default. It arbitrates between four sources: EX-stage jumps, ID-stage load-use hazards, multi-cycle EX ops (div/mul) and external bus stalls. Jumps that arrive during a stall are deferred.

Parameters:
MC_TIMEOUT, 64, max cycles in MC_WAIT before forced release; counter width is clog2(MC_TIMEOUT+1)
RST_PC, 32'h0, value driven on jump_addr_o while idle and during reset

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
jump_en_i  in  1  EX resolved a taken branch/jump this cycle
jump_addr_i  in  32  target for jump_en_i
id_rs1_addr_i  in  5  rs1 of the instruction in ID
id_rs2_addr_i  in  5  rs2 of the instruction in ID
ex_rd_addr_i  in  5  rd of the instruction in EX
ex_reg_wen_i  in  1  EX instruction writes rd
ex_is_load_i  in  1  EX instruction is a load
mc_start_i  in  1  EX issues a multi-cycle op this cycle
mc_done_i  in  1  multi-cycle op result is valid this cycle
bus_stall_i  in  1  memory bus not ready; freeze front end
hold_pc_o  out  1  PC keeps its value
keep_if_id_o  out  1  IF/ID keeps its value
keep_id_ex_o  out  1  ID/EX keeps its value
flush_if_id_o  out  1  IF/ID loads NOP
flush_id_ex_o  out  1  ID/EX loads NOP
jump_en_o  out  1  PC loads jump_addr_o
jump_addr_o  out  32  redirect target
timeout_o  out  1  one-cycle pulse on MC timeout
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset: rst=0 asynchronously sets state=RUN, mc_cnt=0, pend_addr=RST_PC. All 1-bit outputs are 0 and jump_addr_o=RST_PC while rst=0.
- Outputs are combinational from the registered state plus the current inputs. State updates on the clk rising edge.
- States: RUN=2'd0, MC_WAIT=2'd1, JUMP_PEND=2'd2. Encoding 2'd3 is illegal and returns to RUN.
- load_use = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i!=0) & (ex_rd_addr_i==id_rs1_addr_i | ex_rd_addr_i==id_rs2_addr_i).
- RUN, priority highest first:
  1. bus_stall_i & jump_en_i: hold_pc, keep_if_id, keep_id_ex; latch jump_addr_i into pend_addr; next state JUMP_PEND.
  2. bus_stall_i: hold_pc, keep_if_id, keep_id_ex; stay in RUN.
  3. jump_en_i: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id, flush_id_ex in the same cycle. load_use is ignored.
  4. mc_start_i: next state MC_WAIT; no holds in the issuing cycle; mc_cnt cleared.
  5. load_use: hold_pc, keep_if_id, flush_id_ex for exactly one cycle (bubble).
- MC_WAIT:
  - hold_pc, keep_if_id, keep_id_ex asserted every cycle; mc_cnt increments.
  - mc_done_i: holds deassert in that same cycle; next state RUN.
  - mc_cnt==MC_TIMEOUT-1 without mc_done_i: timeout_o=1, flush_id_ex=1, next state RUN.
  - jump_en_i is ignored in MC_WAIT; EX cannot resolve a jump while busy.
- JUMP_PEND:
  - While bus_stall_i is high: holds stay asserted.
  - When bus_stall_i drops: jump_en_o=1, jump_addr_o=pend_addr, flush_if_id, flush_id_ex; next state RUN.
  - A new jump_en_i in JUMP_PEND is ignored; the first pending jump wins.
- Invariant: keep_* and flush_* for the same register are never both 1. Flush has priority.
- mc_start_i and mc_done_i in the same RUN cycle: treat as a single-cycle op and stay in RUN.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0], both reset to 0.
  - stall_cnt_o increments every cycle hold_pc_o=1.
  - flush_cnt_o increments every cycle flush_id_ex_o=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Into defines.v: state encodings (PCTRL_RUN, PCTRL_MC_WAIT, PCTRL_JUMP_PEND). The existing INST_NOP stays there.
- Sub-module pipe_hazard_det: purely combinational load_use compare, reused later for forwarding checks.
- FSM, mc_cnt and pend_addr stay in pipe_ctrl.

Test Plan:
- rst low mid-MC_WAIT (mc_cnt=10) -> state_o=0 immediately; all outputs 0, jump_addr_o=RST_PC; after release, RUN with mc_cnt=0.
- jump_en_i=1, jump_addr_i=32'h100 in RUN -> same cycle jump_en_o=1, jump_addr_o=32'h100, flush_if_id_o=flush_id_ex_o=1.
- ex_is_load_i=1, ex_reg_wen_i=1, ex_rd=5, id_rs2=5 -> one cycle of hold_pc_o=keep_if_id_o=flush_id_ex_o=1; same with ex_rd=0 -> no stall.
- mc_start_i, then mc_done_i after 7 cycles -> keep_id_ex_o high for exactly 7 cycles, then RUN.
- mc_start_i with no done, MC_TIMEOUT=64 -> timeout_o pulses on the 64th wait cycle, flush_id_ex_o=1, then RUN.
- bus_stall_i=1 with jump_en_i=1 at 32'h200, stall held 3 cycles -> holds for 3 cycles, then jump_en_o=1 with 32'h200 and both flushes; a second jump at 32'h300 during the stall is ignored.
